// File: rtl/dm_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : dm_arbiter_if
//  Description : Bundle of the two requester ports (CPU data / DMA) and the
//                single-ported data-memory command bus of dm_arbiter.
//                master : requester / memory model side
//                slave  : arbiter side
//  Ports       : req0/1, we0/1, addr0/1, wdata0/1, pc0  -> arbiter
//                ack0/1, err0/1, rdata0/1, cnt0/1       <- arbiter
//                dm_memWrite, dm_address, dm_writedata,
//                dm_pc                                  <- arbiter
//                dm_readdata                            -> arbiter
//  Revision    : 1.0  initial release
// ============================================================================
interface dm_arbiter_if;
    logic        req0;
    logic        req1;
    logic        we0;
    logic        we1;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic [31:0] pc0;
    logic        ack0;
    logic        ack1;
    logic        err0;
    logic        err1;
    logic [31:0] rdata0;
    logic [31:0] rdata1;
    logic [15:0] cnt0;
    logic [15:0] cnt1;
    logic        dm_memWrite;
    logic [31:0] dm_address;
    logic [31:0] dm_writedata;
    logic [31:0] dm_pc;
    logic [31:0] dm_readdata;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, pc0,
        input  ack0, ack1, err0, err1, rdata0, rdata1, cnt0, cnt1,
        input  dm_memWrite, dm_address, dm_writedata, dm_pc,
        output dm_readdata
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, pc0,
        output ack0, ack1, err0, err1, rdata0, rdata1, cnt0, cnt1,
        output dm_memWrite, dm_address, dm_writedata, dm_pc,
        input  dm_readdata
    );
endinterface
`default_nettype wire

// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dm_arbiter
//  Description : Two-port round-robin arbiter in front of a single-ported data
//                memory. One transaction every three cycles:
//                IDLE (arbitrate/latch) -> SERV (memory command) -> DONE (ack).
//  Ports       : clk   - rising-edge clock
//                reset - asynchronous, active-high reset
//                bus   - dm_arbiter_if.slave (requesters + memory command)
//  Parameters  : ADDR_LIMIT - exclusive upper byte-address bound of the memory
//                CNT_SAT    - ceiling at which the transaction counters stop
//  Revision    : 1.0  initial release
// ============================================================================
module dm_arbiter #(
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_1000,
    parameter logic [15:0] CNT_SAT    = 16'hFFFF
) (
    input  wire logic    clk,
    input  wire logic    reset,
    dm_arbiter_if.slave  bus
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_SERV = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;

    logic        r_last;      // port served most recently
    logic        r_port;      // port of the transaction in flight
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_pc;
    logic [15:0] r_cnt0;
    logic [15:0] r_cnt1;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_any_req;
    logic        w_grant1;
    logic        w_valid;

    assign w_any_req = bus.req0 | bus.req1;
    // Port 1 wins when it is alone, or on a tie when port 0 was served last.
    assign w_grant1  = bus.req1 & (~bus.req0 | ~r_last);
    assign w_valid   = (r_addr < ADDR_LIMIT) && (r_addr[1:0] == 2'b00);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; DONE always returns to IDLE without sampling
    // requests, so a requester has one cycle to drop req after its ack.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (w_any_req) w_state_next = c_SERV;
            c_SERV:  w_state_next = c_DONE;
            c_DONE:  w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: latch the winner in IDLE, capture the response in SERV
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last  <= 1'b1;
            r_port  <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_pc    <= 32'd0;
            r_cnt0  <= 16'd0;
            r_cnt1  <= 16'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            if (r_state == c_IDLE && w_any_req) begin
                r_port <= w_grant1;
                r_last <= w_grant1;
                if (w_grant1) begin
                    r_we    <= bus.we1;
                    r_addr  <= bus.addr1;
                    r_wdata <= bus.wdata1;
                    r_pc    <= 32'd0;   // DMA has no PC to log
                    if (r_cnt1 != CNT_SAT) r_cnt1 <= r_cnt1 + 16'd1;
                end else begin
                    r_we    <= bus.we0;
                    r_addr  <= bus.addr0;
                    r_wdata <= bus.wdata0;
                    r_pc    <= bus.pc0;
                    if (r_cnt0 != CNT_SAT) r_cnt0 <= r_cnt0 + 16'd1;
                end
            end
            if (r_state == c_SERV) begin
                r_rdata <= (w_valid && !r_we) ? bus.dm_readdata : 32'd0;
                r_err   <= ~w_valid;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from the state so that an asynchronous reset
    // drops the memory command and any pending ack at once.
    // ------------------------------------------------------------------
    always_comb begin
        bus.dm_memWrite  = 1'b0;
        bus.dm_address   = 32'd0;
        bus.dm_writedata = 32'd0;
        bus.dm_pc        = 32'd0;
        bus.ack0         = 1'b0;
        bus.ack1         = 1'b0;
        bus.err0         = 1'b0;
        bus.err1         = 1'b0;
        bus.rdata0       = 32'd0;
        bus.rdata1       = 32'd0;
        case (r_state)
            c_SERV: begin
                bus.dm_memWrite  = r_we & w_valid;
                bus.dm_address   = r_addr;
                bus.dm_writedata = r_wdata;
                bus.dm_pc        = r_pc;
            end
            c_DONE: begin
                if (r_port) begin
                    bus.ack1   = 1'b1;
                    bus.err1   = r_err;
                    bus.rdata1 = r_rdata;
                end else begin
                    bus.ack0   = 1'b1;
                    bus.err0   = r_err;
                    bus.rdata0 = r_rdata;
                end
            end
            default: ;
        endcase
    end

    assign bus.cnt0 = r_cnt0;
    assign bus.cnt1 = r_cnt1;

endmodule
`default_nettype wire

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 SHALL have parameter ADDR_LIMIT, default 32'h0000_1000, exclusive upper byte-address bound of the data memory.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have ports req0/req1  input  1  access request from port 0 (CPU data) / port 1 (DMA).
REQ-005 SHALL have ports we0/we1  input  1  write enable: 1 = write, 0 = read.
REQ-006 SHALL have ports addr0/addr1  input  32  byte address.
REQ-007 SHALL have ports wdata0/wdata1  input  32  write data.
REQ-008 SHALL have port pc0  input  32  CPU PC, forwarded to the memory for write logging.
REQ-009 SHALL have ports ack0/ack1  output  1  one-cycle completion pulse.
REQ-010 SHALL have ports err0/err1  output  1  error flag, valid while ackN=1.
REQ-011 SHALL have ports rdata0/rdata1  output  32  read data, valid while ackN=1.
REQ-012 SHALL have ports cnt0/cnt1  output  16  accepted-transaction counters.
REQ-013 SHALL have ports dm_memWrite (output 1), dm_address (output 32), dm_writedata (output 32), dm_pc (output 32): the memory command; dm_readdata (input 32): the memory's combinational read data.

Function
REQ-014 SHALL implement states IDLE, SERV and DONE, plus a 1-bit pointer last (port served most recently).
REQ-015 In IDLE, with any reqN=1, SHALL latch the winner's we, addr, wdata and port id (pc0 if port 0, else 0), increment its cntN, set last, and go to SERV.
REQ-016 Arbitration SHALL be round-robin: if only one request is pending, that port wins; if both are pending, the port != last wins.
REQ-017 In SERV, SHALL drive dm_address/dm_writedata/dm_pc from the latched values for one cycle.
REQ-018 In SERV, dm_memWrite SHALL equal latched we AND the access is valid.
REQ-019 An access SHALL be valid iff addr < ADDR_LIMIT and addr[1:0] == 2'b00.
REQ-020 At the end of SERV, SHALL register rdataN = dm_readdata for a valid read, and 0 for a write or an invalid access.
REQ-021 At the end of SERV, SHALL register errN = !valid and go to DONE.
REQ-022 In DONE, ackN SHALL be 1 for the served port only, for exactly one cycle; the arbiter SHALL then return to IDLE without sampling requests.
REQ-023 Requester rule: reqN SHALL be held stable from assertion until ackN, and deasserted in the cycle after ackN; a reqN still high in IDLE is a new request.
REQ-024 Latency SHALL be exactly: request seen in IDLE at edge N -> SERV cycle N+1 -> ackN high in cycle N+2; one transaction per 3 cycles.
REQ-025 Outside SERV, dm_memWrite SHALL be 0, and dm_address, dm_writedata and dm_pc SHALL be 0.
REQ-026 The non-served port's ack, err and rdata SHALL be 0.
REQ-027 cntN SHALL count accepted transactions, including erroneous ones, and SHALL saturate at 16'hFFFF without wrapping.

Reset
REQ-028 reset=1 SHALL immediately, without waiting for a clock edge, force state=IDLE and last=1 (so port 0 wins the first tie).
REQ-029 reset=1 SHALL clear cnt0 and cnt1 to 0 and drive every output to 0.
REQ-030 Reset asserted during SERV or DONE SHALL abandon the transaction: no memory write after reset asserts, and no ack.
REQ-031 After reset deasserts, the first request SHALL be sampled at the first rising edge with reset=0.

Verification
REQ-032 Single write: req0, we0=1, addr0=0x10, wdata0=0xDEADBEEF, pc0=0x3000 -> dm_memWrite=1 with dm_address=0x10, dm_pc=0x3000 in cycle N+1; ack0=1, err0=0 in N+2; cnt0=1.
REQ-033 Readback: port 1 reads addr1=0x10 after REQ-032 -> rdata1=0xDEADBEEF, ack1=1 in N+2; ack0=0 throughout.
REQ-034 Tie after reset: req0 and req1 both held -> port 0 served first, then port 1, then port 0; acks spaced 3 cycles apart.
REQ-035 Invalid accesses: write to addr 0x1000 and write to addr 0x6 -> dm_memWrite stays 0, err=1 and rdata=0 with ack, counter still increments.
REQ-036 Reset mid-op: reset asserted during SERV of a write -> dm_memWrite falls immediately, no ack, cnt0=cnt1=0, state IDLE.
REQ-037 Saturation: force 65536 port-0 requests -> cnt0=0xFFFF, and still 0xFFFF after one more request.
